remap_tgen: RTL

Output timing generator directly downstream of the remap VS-pulse stage. Each one-cycle frame-start trigger launches exactly one output raster with programmable sync, back-porch and active widths. The block drives out_vs/out_hs/out_de and active-pixel coordinates to the remap read-out logic, all in the mpt_clk domain. It flags triggers that arrive while a frame is still being scanned.

---
 rtl/remap_pkg.sv | 10 +
 rtl/remap_tgen_if.sv | 25 ++
 rtl/remap_tgen_axis.sv | 50 +++++
 rtl/remap_tgen.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/remap_pkg.sv
// Shared types and widths for the remap output timing generator.
package remap_pkg;
   localparam int COORD_W = 12;
   localparam int ERR_W   = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tgen_state_t;
endpackage

// File: rtl/remap_tgen_if.sv
// Trigger inputs and raster outputs between the timing generator and remap read-out.
interface remap_tgen_if;
   import remap_pkg::*;

   logic               vid_vs_trig;
   logic               vid_locked;
   logic               out_vs;
   logic               out_hs;
   logic               out_de;
   logic [COORD_W-1:0] out_x;
   logic [COORD_W-1:0] out_y;
   logic               frame_done;
   logic               trig_err;
   logic [ERR_W-1:0]   trig_err_cnt;

   modport master (
      input  vid_vs_trig, vid_locked,
      output out_vs, out_hs, out_de, out_x, out_y, frame_done, trig_err, trig_err_cnt
   );

   modport slave (
      output vid_vs_trig, vid_locked,
      input  out_vs, out_hs, out_de, out_x, out_y, frame_done, trig_err, trig_err_cnt
   );
endinterface

// File: rtl/remap_tgen_axis.sv
// One raster axis: position counter with wrap, plus sync/active/offset decode of the next position.
module remap_tgen_axis
   import remap_pkg::*;
#(
   parameter logic [COORD_W-1:0] TOTAL = 12'd2200,
   parameter logic [COORD_W-1:0] SYNC  = 12'd44,
   parameter logic [COORD_W-1:0] BP    = 12'd148,
   parameter logic [COORD_W-1:0] ACT   = 12'd1920
) (
   input  logic               mpt_clk,
   input  logic               mpt_arst,
   input  logic               clr,
   input  logic               adv,
   output logic               at_last,
   output logic               sync_p0,
   output logic               act_p0,
   output logic               last_p0,
   output logic [COORD_W-1:0] off_p0
);
   localparam logic [COORD_W-1:0] LAST    = TOTAL - 12'd1;
   localparam logic [COORD_W-1:0] ACT_BEG = SYNC + BP;
   localparam logic [COORD_W-1:0] ACT_END = ACT_BEG + ACT;

   logic [COORD_W-1:0] cnt_q;
   logic [COORD_W-1:0] cnt_nxt;

   assign at_last = (cnt_q == LAST);

   always_comb begin
      cnt_nxt = cnt_q;
      if (clr)
         cnt_nxt = '0;
      else if (adv)
         cnt_nxt = at_last ? '0 : cnt_q + 12'd1;
   end

   // decode looks at the position the counter is about to hold, so the
   // registered outputs downstream line up with the held count
   assign sync_p0 = (cnt_nxt < SYNC);
   assign act_p0  = (cnt_nxt >= ACT_BEG) && (cnt_nxt < ACT_END);
   assign last_p0 = (cnt_nxt == LAST);
   assign off_p0  = cnt_nxt - ACT_BEG;

   always_ff @(posedge mpt_clk) begin
      if (mpt_arst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_nxt;
   end
endmodule

// File: rtl/remap_tgen.sv
// Trigger-launched output raster generator; define REMAP_TGEN_FREERUN_EN for free-running frames
// with trigger resynchronisation instead of one frame per trigger.
module remap_tgen
   import remap_pkg::*;
#(
   parameter logic [COORD_W-1:0] H_TOTAL = 12'd2200,
   parameter logic [COORD_W-1:0] H_SYNC  = 12'd44,
   parameter logic [COORD_W-1:0] H_BP    = 12'd148,
   parameter logic [COORD_W-1:0] H_ACT   = 12'd1920,
   parameter logic [COORD_W-1:0] V_TOTAL = 12'd1125,
   parameter logic [COORD_W-1:0] V_SYNC  = 12'd5,
   parameter logic [COORD_W-1:0] V_BP    = 12'd36,
   parameter logic [COORD_W-1:0] V_ACT   = 12'd1080
) (
   input  logic         mpt_clk,
   input  logic         mpt_arst,
   remap_tgen_if.master bus
);
   if (int'(H_SYNC) + int'(H_BP) + int'(H_ACT) > int'(H_TOTAL)) begin : g_bad_h
      $error("remap_tgen: horizontal sync+bp+active exceeds H_TOTAL");
   end
   if (int'(V_SYNC) + int'(V_BP) + int'(V_ACT) > int'(V_TOTAL)) begin : g_bad_v
      $error("remap_tgen: vertical sync+bp+active exceeds V_TOTAL");
   end
   if (H_SYNC == 0 || H_ACT == 0 || V_SYNC == 0 || V_ACT == 0) begin : g_bad_zero
      $error("remap_tgen: sync and active widths must be non-zero");
   end

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + 8'd1;
   endfunction

   tgen_state_t        state_q;
   tgen_state_t        state_nxt;
   logic               clr, h_adv, v_adv, err_p0, run_p0;
   logic               h_at_last, v_at_last;
   logic               h_sync_p0, h_act_p0, h_last_p0;
   logic               v_sync_p0, v_act_p0, v_last_p0;
   logic [COORD_W-1:0] h_off_p0, v_off_p0;
   logic               de_p0;

   logic               vs_p1, hs_p1, de_p1, done_p1, err_p1;
   logic [COORD_W-1:0] x_p1, y_p1;
   logic [ERR_W-1:0]   err_cnt_q;

   remap_tgen_axis #(.TOTAL(H_TOTAL), .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT)) u_h (
      .mpt_clk (mpt_clk),
      .mpt_arst(mpt_arst),
      .clr     (clr),
      .adv     (h_adv),
      .at_last (h_at_last),
      .sync_p0 (h_sync_p0),
      .act_p0  (h_act_p0),
      .last_p0 (h_last_p0),
      .off_p0  (h_off_p0)
   );

   remap_tgen_axis #(.TOTAL(V_TOTAL), .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT)) u_v (
      .mpt_clk (mpt_clk),
      .mpt_arst(mpt_arst),
      .clr     (clr),
      .adv     (v_adv),
      .at_last (v_at_last),
      .sync_p0 (v_sync_p0),
      .act_p0  (v_act_p0),
      .last_p0 (v_last_p0),
      .off_p0  (v_off_p0)
   );

   always_comb begin
      state_nxt = IDLE;
      clr       = 1'b1;
      h_adv     = 1'b0;
      err_p0    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.vid_vs_trig && bus.vid_locked)
               state_nxt = RUN;
         end
         RUN: begin
            // loss of lock falls through with the defaults: IDLE, counters cleared
            if (bus.vid_locked) begin
               if (h_at_last && v_at_last) begin
`ifdef REMAP_TGEN_FREERUN_EN
                  state_nxt = RUN;
`else
                  if (bus.vid_vs_trig)
                     state_nxt = RUN;
`endif
               end else if (bus.vid_vs_trig) begin
                  state_nxt = RUN;
`ifndef REMAP_TGEN_FREERUN_EN
                  clr       = 1'b0;
                  h_adv     = 1'b1;
                  err_p0    = 1'b1;
`endif
               end else begin
                  state_nxt = RUN;
                  clr       = 1'b0;
                  h_adv     = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   assign v_adv  = h_adv && h_at_last;
   assign run_p0 = (state_nxt == RUN);
   assign de_p0  = run_p0 && h_act_p0 && v_act_p0;

   // ---- output register stage ----
   always_ff @(posedge mpt_clk) begin
      if (mpt_arst) begin
         state_q   <= IDLE;
         vs_p1     <= 1'b0;
         hs_p1     <= 1'b0;
         de_p1     <= 1'b0;
         x_p1      <= '0;
         y_p1      <= '0;
         done_p1   <= 1'b0;
         err_p1    <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q <= state_nxt;
         vs_p1   <= run_p0 && v_sync_p0;
         hs_p1   <= run_p0 && h_sync_p0;
         de_p1   <= de_p0;
         x_p1    <= de_p0 ? h_off_p0 : '0;
         y_p1    <= de_p0 ? v_off_p0 : '0;
         done_p1 <= run_p0 && h_last_p0 && v_last_p0;
         err_p1  <= err_p0;
         if (err_p0)
            err_cnt_q <= sat_inc(err_cnt_q);
      end
   end

   assign bus.out_vs       = vs_p1;
   assign bus.out_hs       = hs_p1;
   assign bus.out_de       = de_p1;
   assign bus.out_x        = x_p1;
   assign bus.out_y        = y_p1;
   assign bus.frame_done   = done_p1;
   assign bus.trig_err     = err_p1;
   assign bus.trig_err_cnt = err_cnt_q;
endmodule
